// File: rtl/muldiv_pkg.sv
// Op encodings, state type and counter width for the mul/div sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [1:0] OP_MUL   = 2'd0;
    localparam logic [1:0] OP_MULHU = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_REMU  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_STEP = 3'd1,
        S_DIV_CMP  = 3'd2,
        S_DIV_SUB  = 3'd3,
        S_DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/rv_constants.sv
// ALU function codes shared across the rvsimple core datapath.
package rv_constants;

    localparam int unsigned ALU_FUNCTION_WIDTH = 5;

    localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_ZERO = 5'b00000;
    localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_ADD  = 5'b00001;
    localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SUB  = 5'b00010;
    localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SLL  = 5'b00011;
    localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SRL  = 5'b00100;
    localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SRA  = 5'b00101;
    localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SEQ  = 5'b00110;
    localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SLT  = 5'b00111;
    localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SLTU = 5'b01000;
    localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_XOR  = 5'b01001;
    localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_OR   = 5'b01010;
    localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_AND  = 5'b01011;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU using the rv_constants function codes.
module alu
    import rv_constants::*;
(
    input  logic [ALU_FUNCTION_WIDTH-1:0] alu_function,
    input  logic [31:0]                   operand_a,
    input  logic [31:0]                   operand_b,
    output logic [31:0]                   result
);

    always_comb begin
        result = 32'd0;
        unique case (alu_function)
            ALU_ADD:  result = operand_a + operand_b;
            ALU_SUB:  result = operand_a - operand_b;
            ALU_SLL:  result = operand_a << operand_b[4:0];
            ALU_SRL:  result = operand_a >> operand_b[4:0];
            ALU_SRA:  result = $signed(operand_a) >>> operand_b[4:0];
            ALU_SEQ:  result = {31'd0, operand_a == operand_b};
            ALU_SLT:  result = {31'd0, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: result = {31'd0, operand_a < operand_b};
            ALU_XOR:  result = operand_a ^ operand_b;
            ALU_OR:   result = operand_a | operand_b;
            ALU_AND:  result = operand_a & operand_b;
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer sharing one ALU for all arithmetic.
module muldiv_sequencer
    import rv_constants::*;
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        busy
);

    state_e                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [XLEN-1:0]         acc_q, acc_d;    // hi (mul) / rem (div)
    logic [XLEN-1:0]         lo_q, lo_d;      // lo (mul) / quo (div)
    logic [XLEN-1:0]         opb_q, opb_d;    // mcand (mul) / div (div)
    logic [CNT_W-1:0]        count_q, count_d;
    logic [XLEN-1:0]         resp_q, resp_d;

    logic [ALU_FUNCTION_WIDTH-1:0] alu_fn;
    logic [XLEN-1:0]         alu_a, alu_b, alu_result;
    logic [XLEN-1:0]         rem_sh;
    logic                    carry;
    logic                    div_step;

    alu u_alu (
        .alu_function (alu_fn),
        .operand_a    (alu_a),
        .operand_b    (alu_b),
        .result       (alu_result)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'd0;
            acc_q   <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            count_q <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            count_q <= count_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        count_d  = count_q;
        resp_d   = resp_q;
        alu_fn   = ALU_ADD;
        alu_a    = acc_q;
        alu_b    = opb_q;
        rem_sh   = {acc_q[XLEN-2:0], lo_q[XLEN-1]};
        carry    = 1'b0;
        div_step = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    count_d = CNT_W'(31);
                    acc_d   = '0;
                    if (req_op == OP_MUL || req_op == OP_MULHU) begin
                        lo_d    = req_b;
                        opb_d   = req_a;
                        state_d = S_MUL_STEP;
                    end else if (req_b == '0) begin
                        resp_d  = (req_op == OP_DIVU) ? '1 : req_a;
                        state_d = S_DONE;
                    end else begin
                        lo_d    = req_a;
                        opb_d   = req_b;
                        state_d = S_DIV_CMP;
                    end
                end
            end
            S_MUL_STEP: begin
                alu_fn = ALU_ADD;
                carry  = (alu_result < opb_q);
                if (lo_q[0]) begin
                    {acc_d, lo_d} = {carry, alu_result, lo_q[XLEN-1:1]};
                end else begin
                    {acc_d, lo_d} = {1'b0, acc_q, lo_q[XLEN-1:1]};
                end
                if (count_q == '0) begin
                    resp_d  = (op_q == OP_MULHU) ? acc_d : lo_d;
                    state_d = S_DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            S_DIV_CMP: begin
                // A set msb means the shifted remainder already exceeds any divisor.
                alu_fn = ALU_SLTU;
                alu_a  = rem_sh;
                acc_d  = rem_sh;
                if (!acc_q[XLEN-1] && alu_result[0]) begin
                    lo_d     = {lo_q[XLEN-2:0], 1'b0};
                    div_step = 1'b1;
                end else begin
                    state_d = S_DIV_SUB;
                end
            end
            S_DIV_SUB: begin
                alu_fn   = ALU_SUB;
                acc_d    = alu_result;
                lo_d     = {lo_q[XLEN-2:0], 1'b1};
                div_step = 1'b1;
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (div_step) begin
            if (count_q == '0) begin
                resp_d  = (op_q == OP_REMU) ? acc_d : lo_d;
                state_d = S_DONE;
            end else begin
                count_d = count_q - CNT_W'(1);
                state_d = S_DIV_CMP;
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign resp_data  = resp_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;

    int checks;
    int failures;

    muldiv_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0:    return prod[31:0];
            2'd1:    return prod[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from accept to resp_valid, counting the accept edge as cycle 1.
    function automatic int model_latency(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        logic [31:0] q;
        if (op < 2'd2) return 33;
        if (b == 0) return 1;
        q = a / b;
        return 33 + $countones(q);
    endfunction

    // Drives one request (called #1 after a rising edge) and collects the response.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clock); #1; n++;
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_op = 2'($urandom); req_a = $urandom; req_b = $urandom;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(posedge clock); #1; lat++;
        end
        if (!resp_valid) lat = -1;
        data = resp_data;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_req_ready got=%b want=1", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        checks++;
        if (resp_data !== 32'd0) begin
            failures++; $display("FAIL reset_resp_data got=%h want=0", resp_data);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [10] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1};
        logic [31:0] as  [10] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100,
                                  32'hFFFF_FFFF, 32'd1234, 32'd1234, 32'd5, 32'd0};
        logic [31:0] bs  [10] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7,
                                  32'h8000_0000, 32'd0, 32'd0, 32'd9, 32'h1234_5678};
        logic [31:0] data;
        int lat;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], as[i], bs[i], data, lat);
            checks++;
            if (data !== model_result(ops[i], as[i], bs[i])) begin
                failures++;
                $display("FAIL directed_data[%0d] op=%0d a=%h b=%h got=%h want=%h", i, ops[i],
                         as[i], bs[i], data, model_result(ops[i], as[i], bs[i]));
            end
            checks++;
            if (lat != model_latency(ops[i], as[i], bs[i])) begin
                failures++;
                $display("FAIL directed_latency[%0d] op=%0d got=%0d want=%0d", i, ops[i], lat,
                         model_latency(ops[i], as[i], bs[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, data;
        int lat;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(15));
                2:       b = $urandom >> $urandom_range(31);
                default: b = $urandom;
            endcase
            run_op(op, a, b, data, lat);
            checks++;
            if (data !== model_result(op, a, b)) begin
                failures++;
                $display("FAIL random_data[%0d] op=%0d a=%h b=%h got=%h want=%h", i, op, a, b,
                         data, model_result(op, a, b));
            end
            checks++;
            if (lat != model_latency(op, a, b)) begin
                failures++;
                $display("FAIL random_latency[%0d] op=%0d got=%0d want=%0d", i, op, lat,
                         model_latency(op, a, b));
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] want;
        int lat;
        want = model_result(2'd2, 32'hCAFE_F00D, 32'd13);
        req_valid = 1'b1; req_op = 2'd2; req_a = 32'hCAFE_F00D; req_b = 32'd13;
        @(posedge clock); #1;
        req_op = 2'd0; req_a = 32'd3; req_b = 32'd5;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(posedge clock); #1; lat++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== want || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold[%0d] valid=%b data=%h ready=%b want valid=1 data=%h ready=0",
                         i, resp_valid, resp_data, req_ready, want);
            end
            @(posedge clock); #1;
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release valid=%b ready=%b want valid=0 ready=1",
                     resp_valid, req_ready);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL second_accept busy=%b want=1", busy);
        end
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(posedge clock); #1; lat++;
        end
        checks++;
        if (resp_data !== 32'd15 || lat != 33) begin
            failures++;
            $display("FAIL second_result data=%h lat=%0d want data=0000000f lat=33", resp_data, lat);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] data;
        int lat;
        bit seen;
        req_valid = 1'b1; req_op = 2'd2; req_a = 32'hDEAD_BEEF; req_b = 32'd3;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (9) begin
            @(posedge clock); #1;
        end
        #2 reset = 1'b0;
        #1;
        test_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(posedge clock); #1;
            if (resp_valid) seen = 1'b1;
        end
        checks++;
        if (seen || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_no_resp seen=%b ready=%b want seen=0 ready=1", seen, req_ready);
        end
        run_op(2'd0, 32'd3, 32'd5, data, lat);
        checks++;
        if (data !== 32'd15 || lat != 33) begin
            failures++;
            $display("FAIL reset_mid_mul data=%h lat=%0d want data=0000000f lat=33", data, lat);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = 32'd0; req_b = 32'd0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        test_directed();
        test_random();
        test_back_pressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle unsigned multiply/divide sequencer for the rvsimple core. It accepts one MUL/MULHU/DIVU/REMU request at a time and iterates shift-add multiplication or restoring division. All add, subtract and compare steps go through one private `alu` instance driven with the standard `rv_constants` ALU function codes. It sits beside the execute stage, and the core stalls on `busy`.

## Interface
- No parameters. Width is fixed at 32 to match the `alu` datapath.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept; equals (state == IDLE).
- `req_op` in 2: 0 = MUL (low word), 1 = MULHU (high word), 2 = DIVU, 3 = REMU.
- `req_a` in 32: multiplicand or dividend.
- `req_b` in 32: multiplier or divisor.
- `resp_valid` out 1: result present; equals (state == DONE).
- `resp_ready` in 1: consumer takes the result.
- `resp_data` out 32: result; stable while `resp_valid` is high.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, MUL_STEP, DIV_CMP, DIV_SUB, DONE.
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `busy` 0, `resp_data` 0, all internal registers 0.
- Accept occurs on an edge with `req_valid && req_ready`, which latches the op and operands.
- MUL/MULHU setup: hi = 0, lo = `req_b`, mcand = `req_a`, count = 31; next state MUL_STEP.
- MUL_STEP:
  - The ALU runs ALU_ADD(hi, mcand).
  - carry = (sum < mcand), computed locally as a 33rd bit.
  - If lo[0] = 1: {hi, lo} <= {carry, sum, lo} >> 1. Otherwise: {hi, lo} <= {1'b0, hi, lo} >> 1.
  - When count = 0, go to DONE; otherwise decrement count.
- DIVU/REMU setup:
  - If `req_b` == 0: result is 0xFFFFFFFF (DIVU) or `req_a` (REMU); go straight to DONE.
  - Otherwise: rem = 0, quo = `req_a`, div = `req_b`, count = 31; next state DIV_CMP.
- DIV_CMP:
  - Form rem_sh = {rem[30:0], quo[31]}, with msb = rem[31].
  - The ALU runs ALU_SLTU(rem_sh, div).
  - If msb = 0 and the ALU result is 1: rem <= rem_sh, quo <= {quo[30:0], 0}, then step the counter.
  - Otherwise: rem <= rem_sh, go to DIV_SUB.
- DIV_SUB:
  - The ALU runs ALU_SUB(rem, div); the result wraps mod 2^32, which is exact.
  - rem <= diff, quo <= {quo[30:0], 1}, then step the counter.
- Counter step (DIV): if count = 0, go to DONE; otherwise decrement count and go to DIV_CMP.
- DONE: `resp_data` = lo (MUL), hi (MULHU), quo (DIVU) or rem (REMU). On `resp_ready`, go to IDLE.
- The ALU function input is ALU_ADD in IDLE and DONE; the ALU result is ignored there.

## Timing
- The response registers are written with the state, so there is no combinational path from `req_*` to `resp_*`.
- MUL/MULHU: `resp_valid` rises exactly 33 cycles after the accept edge.
- DIVU/REMU, nonzero divisor: `resp_valid` rises 32 + S + 1 cycles after accept, where S = number of DIV_SUB visits (quotient 1-bits plus forced subtracts).
- Divide by zero: `resp_valid` rises 1 cycle after accept.
- Back-to-back requests: `req_ready` returns one cycle after the `resp_valid && resp_ready` edge, giving a minimum 1-cycle bubble.
- Back-pressure: with `resp_ready` low, DONE holds indefinitely and `resp_data` does not change.
- `req_*` inputs are ignored outside IDLE, even when valid.
- Reset asserted mid-operation:
  - All registers clear asynchronously.
  - The in-flight operation is lost and no response is produced.
  - After deassertion the block is in IDLE with `req_ready` = 1.

## Structure
- Package `muldiv_pkg` holds:
  - the op encoding constants MUL/MULHU/DIVU/REMU;
  - the state enum typedef;
  - the count width (5).
- ALU function codes are imported from `rv_constants`; they are not redefined.
- One sub-module: `alu`, instantiated once as the shared datapath.
- All sequencing lives in a single always_ff (async reset) plus one always_comb for ALU operand and function select.

## Test plan
- MUL 7 × 6: `resp_data` = 42, `resp_valid` at cycle 33 after accept.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF: `resp_data` = 0xFFFFFFFE. MUL on the same operands gives 0x00000001.
- DIVU 100 / 7: 14 at cycle 36. REMU 100 / 7: 2 at cycle 36. DIVU 0xFFFFFFFF / 0x80000000: 1, which exercises the forced-subtract path.
- DIVU 1234 / 0: 0xFFFFFFFF at cycle 1. REMU 1234 / 0: 1234 at cycle 1.
- Back-pressure: hold `resp_ready` low for 5 cycles.
  - Required: `resp_data` stable and `req_ready` low throughout, even while a second `req_valid` is held.
  - The second request is accepted only after the first response is taken.
- Reset mid-DIVU (cycle 10):
  - Outputs go to reset values immediately.
  - No `resp_valid` appears.
  - A following MUL 3 × 5 returns 15.
